// File: rtl/dec_func_digital.sv
// Registered 3-to-8 decoder with three mask-programmable sum-of-minterms outputs.
// The f outputs are built from the same d_next vector as the d outputs, so both always describe the same select.
module dec_func_digital #(
    parameter logic [7:0] F1_MASK = 8'b1001_0110,
    parameter logic [7:0] F2_MASK = 8'b1110_1000,
    parameter logic [7:0] F3_MASK = 8'b0001_0111
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic d4,
    output logic d5,
    output logic d6,
    output logic d7,
    output logic f1,
    output logic f2,
    output logic f3
);

    logic [2:0] sel;
    logic [7:0] d_next;
    logic       f1_next;
    logic       f2_next;
    logic       f3_next;
    logic [7:0] d_q;
    logic       f1_q;
    logic       f2_q;
    logic       f3_q;

    assign sel = {a, b, c};

    always_comb begin
        d_next  = 8'b0000_0001 << sel;
        f1_next = |(F1_MASK & d_next);
        f2_next = |(F2_MASK & d_next);
        f3_next = |(F3_MASK & d_next);
    end

    // Reset clears everything regardless of mask, so an all-ones mask reads 0 until the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= 8'h00;
            f1_q <= 1'b0;
            f2_q <= 1'b0;
            f3_q <= 1'b0;
        end else begin
            d_q  <= d_next;
            f1_q <= f1_next;
            f2_q <= f2_next;
            f3_q <= f3_next;
        end
    end

    assign d0 = d_q[0];
    assign d1 = d_q[1];
    assign d2 = d_q[2];
    assign d3 = d_q[3];
    assign d4 = d_q[4];
    assign d5 = d_q[5];
    assign d6 = d_q[6];
    assign d7 = d_q[7];
    assign f1 = f1_q;
    assign f2 = f2_q;
    assign f3 = f3_q;

endmodule

// File: tb/tb_dec_func_digital.sv
// Directed bench for dec_func_digital: default-mask instance plus a mask-override instance.
module tb_dec_func_digital;

    localparam logic [7:0] M1 = 8'b1001_0110;
    localparam logic [7:0] M2 = 8'b1110_1000;
    localparam logic [7:0] M3 = 8'b0001_0111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;

    logic u_d0, u_d1, u_d2, u_d3, u_d4, u_d5, u_d6, u_d7, u_f1, u_f2, u_f3;
    logic v_d0, v_d1, v_d2, v_d3, v_d4, v_d5, v_d6, v_d7, v_f1, v_f2, v_f3;

    int errors = 0;
    int checks = 0;

    // Hand-written expectation tables for the default masks, indexed by m.
    bit tab_f1 [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    bit tab_f2 [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    bit tab_f3 [8] = '{1, 1, 1, 0, 1, 0, 0, 0};

    always #5 clk = ~clk;

    dec_func_digital u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .d0(u_d0), .d1(u_d1), .d2(u_d2), .d3(u_d3),
        .d4(u_d4), .d5(u_d5), .d6(u_d6), .d7(u_d7),
        .f1(u_f1), .f2(u_f2), .f3(u_f3)
    );

    dec_func_digital #(
        .F1_MASK(8'h00),
        .F2_MASK(8'hFF),
        .F3_MASK(8'h80)
    ) v_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .d0(v_d0), .d1(v_d1), .d2(v_d2), .d3(v_d3),
        .d4(v_d4), .d5(v_d5), .d6(v_d6), .d7(v_d7),
        .f1(v_f1), .f2(v_f2), .f3(v_f3)
    );

    wire [7:0] u_d = {u_d7, u_d6, u_d5, u_d4, u_d3, u_d2, u_d1, u_d0};
    wire [2:0] u_f = {u_f1, u_f2, u_f3};
    wire [7:0] v_d = {v_d7, v_d6, v_d5, v_d4, v_d3, v_d2, v_d1, v_d0};
    wire [2:0] v_f = {v_f1, v_f2, v_f3};

    // Drive the select shortly after an edge, then step to just past the edge that captures it.
    task automatic applyStimulus(input logic [2:0] m);
        {a, b, c} = m;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] exp_ud, input logic [2:0] exp_uf,
                               input logic [7:0] exp_vd, input logic [2:0] exp_vf);
        checks++;
        assert (u_d === exp_ud) else begin
            errors++;
            $error("[TB] FAIL %s dflt_d observed=%b expected=%b", tag, u_d, exp_ud);
        end
        checks++;
        assert (u_f === exp_uf) else begin
            errors++;
            $error("[TB] FAIL %s dflt_f123 observed=%b expected=%b", tag, u_f, exp_uf);
        end
        checks++;
        assert (v_d === exp_vd) else begin
            errors++;
            $error("[TB] FAIL %s ovr_d observed=%b expected=%b", tag, v_d, exp_vd);
        end
        checks++;
        assert (v_f === exp_vf) else begin
            errors++;
            $error("[TB] FAIL %s ovr_f123 observed=%b expected=%b", tag, v_f, exp_vf);
        end
    endtask

    initial begin
        logic [2:0] m;
        logic [7:0] onehot;

        $display("[TB] start");

        // Reset held with select 111 while the clock runs.
        rst_n = 1'b0;
        {a, b, c} = 3'b111;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_hold", 8'h00, 3'b000, 8'h00, 3'b000);

        rst_n = 1'b1;
        #1;
        checkOutput("reset_release_pre_edge", 8'h00, 3'b000, 8'h00, 3'b000);
        applyStimulus(3'b111);
        checkOutput("reset_first_edge", 8'h80, 3'b110, 8'h80, 3'b011);

        // Exhaustive sweep: default masks from tables, override masks 00/FF/80.
        for (int k = 0; k < 8; k++) begin
            m = 3'(k);
            onehot = 8'h01 << k;
            applyStimulus(m);
            checkOutput($sformatf("sweep_m%0d", k), onehot,
                        {tab_f1[k], tab_f2[k], tab_f3[k]},
                        onehot, {1'b0, 1'b1, (k == 7) ? 1'b1 : 1'b0});
        end

        // Latency: 000 captured, then 101 driven just after an edge must not show until the next edge.
        applyStimulus(3'b000);
        checkOutput("lat_m0", 8'h01, 3'b001, 8'h01, 3'b010);
        {a, b, c} = 3'b101;
        #3;
        checkOutput("lat_before_edge", 8'h01, 3'b001, 8'h01, 3'b010);
        @(posedge clk);
        #2;
        checkOutput("lat_after_edge", 8'h20, 3'b010, 8'h20, 3'b010);

        // Glitch between edges has no effect.
        {a, b, c} = 3'b010;
        #2;
        {a, b, c} = 3'b101;
        #1;
        checkOutput("glitch_ignored", 8'h20, 3'b010, 8'h20, 3'b010);
        @(posedge clk);
        #2;

        // Asynchronous reset mid-run at m = 3.
        applyStimulus(3'b011);
        checkOutput("pre_async_m3", 8'h08, 3'b010, 8'h08, 3'b010);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 8'h00, 3'b000, 8'h00, 3'b000);
        @(posedge clk);
        #2;
        checkOutput("async_reset_held", 8'h00, 3'b000, 8'h00, 3'b000);
        rst_n = 1'b1;
        applyStimulus(3'b011);
        checkOutput("resume_m3", 8'h08, 3'b010, 8'h08, 3'b010);
        applyStimulus(3'b110);
        checkOutput("resume_m6", 8'h40, 3'b010, 8'h40, 3'b010);

        // Random back-to-back selects against an independent mask model.
        for (int i = 0; i < 1000; i++) begin
            m = 3'($urandom_range(0, 7));
            onehot = 8'h01 << m;
            applyStimulus(m);
            checkOutput($sformatf("rand_%0d_m%0d", i, m), onehot,
                        {M1[m], M2[m], M3[m]},
                        onehot, {1'b0, 1'b1, (m == 3'd7) ? 1'b1 : 1'b0});
            checks++;
            assert ($countones(u_d) == 1) else begin
                errors++;
                $error("[TB] FAIL rand_onehot_%0d observed=%b expected=one bit set", i, u_d);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
